// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, instruction-memory addressing,
// IF/ID pipeline register, halt handling and saturating stall/flush counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        flush,
   input  logic        branch_taken,
   input  logic [31:0] branch_target,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_data,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_valid,
   output logic        halted,
   output logic [15:0] stall_count,
   output logic [15:0] flush_count
);

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned OPC_W = 6;

   typedef enum logic [0:0] {
      S_RUN  = 1'b0,
      S_HALT = 1'b1
   } state_e;

   // IF/ID register payload handed to decode
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic            valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '0;

   state_e           state_q, state_d;
   logic [XLEN-1:0]  pc_q, pc_d;
   ifid_t            ifid_q, ifid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   logic [XLEN-1:0]  pc_inc_c;
   logic             halt_word_c;

   // Counter increment that sticks at all-ones
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

   // Sequential PC increment (wraps naturally) and halt-opcode decode
   always_comb begin
      pc_inc_c    = pc_q + XLEN'(1);
      halt_word_c = (imem_data[XLEN-1 -: OPC_W] == HALT_OPCODE);
   end

   // Next-state logic in priority order: redirect, flush, stall, halt, fetch
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      ifid_d      = ifid_q;
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;

      if (branch_taken) begin
         // Redirect beats stall and flush and is the only exit from HALT
         pc_d        = branch_target;
         ifid_d      = IFID_BUBBLE;
         state_d     = S_RUN;
         flush_cnt_d = sat_inc(flush_cnt_q);
      end else if (flush) begin
         // Fetched word is discarded, so its opcode is never inspected
         ifid_d      = IFID_BUBBLE;
         flush_cnt_d = sat_inc(flush_cnt_q);
         if (!stall && (state_q == S_RUN)) begin
            pc_d = pc_inc_c;
         end
      end else if (stall) begin
         stall_cnt_d = sat_inc(stall_cnt_q);
      end else begin
         unique case (state_q)
            S_HALT: begin
               ifid_d = IFID_BUBBLE;
            end
            S_RUN: begin
               ifid_d.pc    = pc_inc_c;
               ifid_d.instr = imem_data;
               ifid_d.valid = 1'b1;
               pc_d         = pc_inc_c;
               if (halt_word_c) begin
                  state_d = S_HALT;
               end
            end
            default: begin
               state_d = S_RUN;
            end
         endcase
      end
   end

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_RUN;
         pc_q        <= RESET_PC;
         ifid_q      <= IFID_BUBBLE;
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         ifid_q      <= ifid_d;
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // Output mapping; only the memory address is combinational from the PC
   assign imem_addr   = pc_q;
   assign id_pc       = ifid_q.pc;
   assign id_instr    = ifid_q.instr;
   assign id_valid    = ifid_q.valid;
   assign halted      = (state_q == S_HALT);
   assign stall_count = stall_cnt_q;
   assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural reference model plus
// directed scenarios with hand-computed literal expectations.
module tb_fetch_stage;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_valid;
   logic        halted;
   logic [15:0] stall_count;
   logic [15:0] flush_count;

   int checks = 0;
   int errors = 0;

   fetch_stage #(
      .RESET_PC   (32'h0000_0000),
      .HALT_OPCODE(6'h3F)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .flush        (flush),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .imem_addr    (imem_addr),
      .imem_data    (imem_data),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_valid     (id_valid),
      .halted       (halted),
      .stall_count  (stall_count),
      .flush_count  (flush_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: a halt word at address 7, otherwise 0x2000_0000+addr
   function automatic logic [31:0] imem_word(input logic [31:0] a);
      if (a == 32'd7) return 32'hFC00_0000;
      return 32'h2000_0000 + a;
   endfunction

   always_comb imem_data = imem_word(imem_addr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Reference model: architectural view of the fetch stage
   logic [31:0] m_pc;
   logic [31:0] m_id_pc;
   logic [31:0] m_id_instr;
   logic        m_valid;
   logic        m_halted;
   int          m_stalls;
   int          m_flushes;

   always @(posedge clk) begin
      if (!rst) begin
         m_pc = 32'h0; m_id_pc = 32'h0; m_id_instr = 32'h0; m_valid = 1'b0;
         m_halted = 1'b0; m_stalls = 0; m_flushes = 0;
      end else if (branch_taken) begin
         m_pc = branch_target;
         m_id_pc = 32'h0; m_id_instr = 32'h0; m_valid = 1'b0;
         m_halted = 1'b0;
         if (m_flushes < 65535) m_flushes++;
      end else if (flush) begin
         m_id_pc = 32'h0; m_id_instr = 32'h0; m_valid = 1'b0;
         if (m_flushes < 65535) m_flushes++;
         if (!stall && !m_halted) m_pc = m_pc + 32'd1;
      end else if (stall) begin
         if (m_stalls < 65535) m_stalls++;
      end else if (m_halted) begin
         m_id_pc = 32'h0; m_id_instr = 32'h0; m_valid = 1'b0;
      end else begin
         m_id_instr = imem_word(m_pc);
         m_id_pc    = m_pc + 32'd1;
         m_valid    = 1'b1;
         if (m_id_instr[31:26] == 6'h3F) m_halted = 1'b1;
         m_pc = m_pc + 32'd1;
      end
   end

   // Compare every output against the model on each falling edge
   always @(negedge clk) begin
      check("imem_addr", imem_addr, m_pc);
      check("id_pc", id_pc, m_id_pc);
      check("id_instr", id_instr, m_id_instr);
      check("id_valid", 32'(id_valid), 32'(m_valid));
      check("halted", 32'(halted), 32'(m_halted));
      check("stall_count", 32'(stall_count), 32'(m_stalls));
      check("flush_count", 32'(flush_count), 32'(m_flushes));
   end

   // One clock edge, returning at the following falling edge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_imem_addr"}, imem_addr, 32'h0);
      check({tag, "_id_pc"}, id_pc, 32'h0);
      check({tag, "_id_instr"}, id_instr, 32'h0);
      check({tag, "_id_valid"}, 32'(id_valid), 32'h0);
      check({tag, "_halted"}, 32'(halted), 32'h0);
      check({tag, "_stall_count"}, 32'(stall_count), 32'h0);
      check({tag, "_flush_count"}, 32'(flush_count), 32'h0);
   endtask

   initial begin
      rst = 1'b0; stall = 1'b0; flush = 1'b0;
      branch_taken = 1'b0; branch_target = 32'h0;
      tick(); tick();
      check_reset_outputs("rst0");

      // Straight-line fetch after reset
      rst = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         tick();
         check("run_id_pc", id_pc, 32'(i));
         check("run_id_instr", id_instr, 32'h2000_0000 + 32'(i - 1));
         check("run_id_valid", 32'(id_valid), 32'h1);
      end
      check("run_imem_addr", imem_addr, 32'h4);

      // Stall three cycles at PC=5
      tick();
      check("pre_stall_addr", imem_addr, 32'h5);
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_id_instr", id_instr, 32'h2000_0004);
         check("stall_imem_addr", imem_addr, 32'h5);
      end
      check("stall_count3", 32'(stall_count), 32'h3);
      stall = 1'b0;
      tick();
      check("resume_id_instr", id_instr, 32'h2000_0005);
      check("resume_id_pc", id_pc, 32'h6);

      // Run into the halt word at address 7
      tick();
      tick();
      check("halt_id_instr", id_instr, 32'hFC00_0000);
      check("halt_id_valid", 32'(id_valid), 32'h1);
      check("halt_halted", 32'(halted), 32'h1);
      check("halt_imem_addr", imem_addr, 32'h8);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("halt_bubble_valid", 32'(id_valid), 32'h0);
         check("halt_frozen_addr", imem_addr, 32'h8);
      end

      // Branch out of HALT
      branch_taken = 1'b1; branch_target = 32'h10;
      tick();
      branch_taken = 1'b0;
      check("unhalt_halted", 32'(halted), 32'h0);
      check("unhalt_addr", imem_addr, 32'h10);
      check("unhalt_bubble", 32'(id_valid), 32'h0);
      check("unhalt_flush_count", 32'(flush_count), 32'h1);
      tick();
      check("unhalt_id_instr", id_instr, 32'h2000_0010);
      check("unhalt_id_pc", id_pc, 32'h11);

      // Branch while stalled: branch wins, stall counter untouched
      stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40;
      tick();
      stall = 1'b0; branch_taken = 1'b0;
      check("brstall_addr", imem_addr, 32'h40);
      check("brstall_valid", 32'(id_valid), 32'h0);
      check("brstall_flush_count", 32'(flush_count), 32'h2);
      check("brstall_stall_count", 32'(stall_count), 32'h3);
      tick();
      check("brstall_id_instr", id_instr, 32'h2000_0040);
      check("brstall_id_pc", id_pc, 32'h41);

      // Flush alone advances PC; flush with stall holds it
      flush = 1'b1;
      tick();
      check("flush_addr", imem_addr, 32'h42);
      check("flush_valid", 32'(id_valid), 32'h0);
      stall = 1'b1;
      tick();
      check("flushstall_addr", imem_addr, 32'h42);
      check("flushstall_flush_count", 32'(flush_count), 32'h4);
      check("flushstall_stall_count", 32'(stall_count), 32'h3);
      flush = 1'b0; stall = 1'b0;
      tick();
      check("postflush_id_instr", id_instr, 32'h2000_0042);

      // PC wrap
      branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
      tick();
      branch_taken = 1'b0;
      check("wrap_addr", imem_addr, 32'hFFFF_FFFF);
      tick();
      check("wrap_id_pc", id_pc, 32'h0);
      check("wrap_id_instr", id_instr, 32'h1FFF_FFFF);
      check("wrap_next_addr", imem_addr, 32'h0);

      // Fetch 0..7 to halt again, then flush while halted must not move PC
      for (int i = 0; i < 8; i++) tick();
      check("halt2_halted", 32'(halted), 32'h1);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("halt_flush_addr", imem_addr, 32'h8);
      check("halt_flush_halted", 32'(halted), 32'h1);

      // Long stall saturates the stall counter
      stall = 1'b1;
      for (int i = 0; i < 70000; i++) tick();
      check("stall_sat", 32'(stall_count), 32'h0000_FFFF);

      // Reset overrides a simultaneous branch
      rst = 1'b0; branch_taken = 1'b1; branch_target = 32'h123;
      tick();
      rst = 1'b1; branch_taken = 1'b0; stall = 1'b0;
      check_reset_outputs("rst1");
      tick();
      check("post_rst_id_instr", id_instr, 32'h2000_0000);
      check("post_rst_id_pc", id_pc, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the five-stage MIPS pipeline: owns the program counter, drives the instruction-memory address, and produces the IF/ID register contents consumed by the decode stage. It handles hazard-unit stalls, branch redirects and flushes, plus a halt opcode that freezes fetch. It also keeps saturating stall and flush counters for performance debug. It replaces the loose PC, PC-adder and IF2ID wiring in the CPU top level.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- HALT_OPCODE, 6'h3F, opcode field (instr[31:26]) that halts fetch

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  1  hazard unit: hold PC and IF/ID
- flush  in  1  discard the instruction being fetched this cycle
- branch_taken  in  1  redirect from EX/MEM; overrides stall
- branch_target  in  32  word address to fetch next when branch_taken=1
- imem_addr  out  32  instruction-memory word address; combinational copy of PC
- imem_data  in  32  instruction at imem_addr; combinational read
- id_pc  out  32  PC+1 of the instruction in IF/ID
- id_instr  out  32  instruction in IF/ID; 32'h0 (NOP) when bubble
- id_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch FSM in HALT
- stall_count  out  16  cycles with stall applied; saturating
- flush_count  out  16  cycles with a flush or redirect; saturating

## Operation
- PC is word-addressed. Increment is +1 in 32-bit arithmetic and wraps from 32'hFFFF_FFFF to 0.
- Bubble means: id_pc=0, id_instr=0, id_valid=0.
- FSM has two states:
  - RUN: normal fetch.
  - HALT: PC frozen, IF/ID receives bubbles.
- Per-edge priority, highest first:
  1. rst=0: PC=RESET_PC, IF/ID bubble, state RUN, both counters 0.
  2. branch_taken=1: PC=branch_target, IF/ID bubble, state RUN, flush_count+1. Stall and flush are ignored.
  3. flush=1: IF/ID bubble, flush_count+1. PC holds if stall=1 or state=HALT; otherwise PC+1. The halt check is not applied to the discarded word. stall_count is not incremented.
  4. stall=1: PC, IF/ID and state hold; stall_count+1.
  5. state HALT: PC holds, IF/ID bubble.
  6. state RUN: IF/ID={PC+1, imem_data, 1}, PC=PC+1. If imem_data[31:26]==HALT_OPCODE, next state is HALT.
- The halt instruction itself enters IF/ID with id_valid=1. Fetch stops after it.
- Only a taken branch (or reset) leaves HALT. This allows a mispredicted halt to be cancelled.
- Counters stick at 16'hFFFF.

## Timing
- All outputs are registered except imem_addr, which is combinational from PC.
- Reset values: imem_addr=RESET_PC, id_pc=0, id_instr=0, id_valid=0, halted=0, stall_count=0, flush_count=0.
- Fetch-to-decode latency: 1 cycle. The word at imem_addr in cycle N appears on id_instr in cycle N+1.
- Redirect: branch_taken sampled at edge N. imem_addr=branch_target from N. id_valid=0 during cycle N+1. The target instruction is on id_instr after edge N+1.
- Stall is level-sensitive. With stall held for K cycles: IF/ID is unchanged K cycles, stall_count+K, and no instruction is lost or duplicated.
- halted rises the edge after the halt word is fetched, together with id_valid=1 for that word. From the next edge, id_valid=0.
- Reset mid-operation overrides everything, including branch_taken, within one edge.

## Test plan
- Reset then run, imem[i]=32'h2000_0000+i: after reset, cycles 1..4 show id_pc=1..4, id_instr=32'h2000_0000..32'h2000_0003, id_valid=1; imem_addr=4 after 4 edges.
- Stall 3 cycles at PC=5: id_instr stays imem[4] and imem_addr stays 5 for 3 cycles, stall_count=3; release resumes with imem[5], no duplicate.
- branch_taken with branch_target=32'h40 while stall=1: imem_addr=32'h40 next cycle, one bubble (id_valid=0), then id_instr=imem[32'h40], id_pc=32'h41; flush_count=1, stall_count unchanged.
- Halt word 32'hFC00_0000 at address 7: id_instr=32'hFC00_0000 with id_valid=1, halted=1, imem_addr frozen at 8, then bubbles for 10 cycles; branch_taken to 32'h10 clears halted and resumes fetch at 32'h10.
- PC wrap: branch to 32'hFFFF_FFFF: id_pc=0 for that instruction, imem_addr=0 next.
- Stall held 70000 cycles: stall_count saturates at 16'hFFFF; rst=0 for one cycle returns all outputs to reset values.
